tmr_cnt_core: RTL and testbench

Parametrised timer counter core, the next generation of the single 8-bit counter unit: configurable width, three counting modes (free-run wrap, auto-reload, one-shot), compare match, and per-event pulse plus sticky status outputs. Sits between the timer register block (which supplies load/reload/compare values and clears flags) and the clock-source selector (which supplies `tmr_edge`). All logic is in the `pclk` domain.

---
 rtl/tmr_cnt_core.sv | 174 +++++++++++++++++
 tb/tb_tmr_cnt_core.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_cnt_core.sv
// -----------------------------------------------------------------------------
// tmr_cnt_core
//
// Parametrised timer counter core. Counts on qualified tmr_edge pulses while
// enabled, in free-run (wrap), auto-reload or one-shot mode, up or down.
// Raises registered one-cycle event pulses for overflow, underflow and compare
// match, each backed by a sticky write-1-to-clear flag.
//
// Parameters
//   CNT_WIDTH      counter width in bits (>= 2)
//   TCNT_RST       reset value of tcnt
//
// Ports
//   pclk           system clock, rising edge
//   preset_n       asynchronous active-low reset
//   tmr_edge       one-pclk count-step qualifier from the clock-source selector
//   cnt_enable     counting enabled
//   cnt_load       load cnt_load_value into tcnt (wins over a step)
//   cnt_load_value value taken by a load
//   cnt_dir        0 = count up, 1 = count down
//   cnt_mode       00 free-run, 01 auto-reload, 10 one-shot, 11 as free-run
//   reload_value   value taken at terminal count in auto-reload mode
//   cmp_value      compare value
//   flag_clr       write-1-to-clear: bit0 ovf, bit1 udf, bit2 cmp
//   tcnt           current count
//   ovf/udf/cmp_pulse  one-cycle event pulses, aligned with the new tcnt
//   ovf/udf/cmp_flag   sticky event flags
//   running        high while in RUN
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not counting; waits for cnt_enable
//   RUN     | counting on each qualified tmr_edge
//   DONE    | one-shot expired, tcnt held at terminal; load or disable
//           | returns to IDLE
// -----------------------------------------------------------------------------
module tmr_cnt_core #(
   parameter int unsigned          CNT_WIDTH = 8,
   parameter logic [CNT_WIDTH-1:0] TCNT_RST  = '0
) (
   input  logic                 pclk,
   input  logic                 preset_n,
   input  logic                 tmr_edge,
   input  logic                 cnt_enable,
   input  logic                 cnt_load,
   input  logic [CNT_WIDTH-1:0] cnt_load_value,
   input  logic                 cnt_dir,
   input  logic [1:0]           cnt_mode,
   input  logic [CNT_WIDTH-1:0] reload_value,
   input  logic [CNT_WIDTH-1:0] cmp_value,
   input  logic [2:0]           flag_clr,
   output logic [CNT_WIDTH-1:0] tcnt,
   output logic                 ovf_pulse,
   output logic                 udf_pulse,
   output logic                 cmp_pulse,
   output logic                 ovf_flag,
   output logic                 udf_flag,
   output logic                 cmp_flag,
   output logic                 running
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0]           MODE_RELOAD  = 2'b01;
   localparam logic [1:0]           MODE_ONESHOT = 2'b10;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   tcnt_q, tcnt_d;
   logic                   ovf_pulse_q, ovf_pulse_d;
   logic                   udf_pulse_q, udf_pulse_d;
   logic                   cmp_pulse_q, cmp_pulse_d;
   logic [2:0]             flags_q, flags_d;

   logic                   step;
   logic                   at_term;
   logic                   term_step;

   // Step qualification and terminal detection
   always_comb begin
      step      = cnt_enable && tmr_edge && (state_q == ST_RUN) && !cnt_load;
      at_term   = cnt_dir ? (tcnt_q == CNT_ZERO) : (tcnt_q == CNT_MAX);
      term_step = step && at_term;
   end

   // Counter datapath and event generation
   always_comb begin
      tcnt_d      = tcnt_q;
      ovf_pulse_d = 1'b0;
      udf_pulse_d = 1'b0;
      cmp_pulse_d = 1'b0;

      if (cnt_load) begin
         // Loads never generate events, including compare.
         tcnt_d = cnt_load_value;
      end else if (step) begin
         if (!at_term) begin
            tcnt_d = cnt_dir ? (tcnt_q - CNT_ONE) : (tcnt_q + CNT_ONE);
         end else begin
            ovf_pulse_d = !cnt_dir;
            udf_pulse_d = cnt_dir;
            case (cnt_mode)
               MODE_RELOAD:  tcnt_d = reload_value;
               MODE_ONESHOT: tcnt_d = tcnt_q;
               default:      tcnt_d = cnt_dir ? CNT_MAX : CNT_ZERO;
            endcase
         end
         // Compare sees the value this step produces, so a wrap or reload
         // that lands on cmp_value fires together with ovf/udf.
         cmp_pulse_d = (tcnt_d == cmp_value);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!cnt_enable) begin
               state_d = ST_IDLE;
            end else if (term_step && (cnt_mode == MODE_ONESHOT)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (cnt_load || !cnt_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky flags: a new event outranks a clear in the same cycle.
   always_comb begin
      flags_d = {cmp_pulse_d, udf_pulse_d, ovf_pulse_d} | (flags_q & ~flag_clr);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= TCNT_RST;
         ovf_pulse_q <= 1'b0;
         udf_pulse_q <= 1'b0;
         cmp_pulse_q <= 1'b0;
         flags_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         ovf_pulse_q <= ovf_pulse_d;
         udf_pulse_q <= udf_pulse_d;
         cmp_pulse_q <= cmp_pulse_d;
         flags_q     <= flags_d;
      end
   end

   assign tcnt      = tcnt_q;
   assign ovf_pulse = ovf_pulse_q;
   assign udf_pulse = udf_pulse_q;
   assign cmp_pulse = cmp_pulse_q;
   assign ovf_flag  = flags_q[0];
   assign udf_flag  = flags_q[1];
   assign cmp_flag  = flags_q[2];
   assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_tmr_cnt_core.sv
// -----------------------------------------------------------------------------
// tb_tmr_cnt_core
//
// Bench for tmr_cnt_core: an 8-bit instance driven by a directed vector table
// and then random stimulus against a behavioural model, and a 16-bit instance
// exercised by a short hand-written sequence including an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tmr_cnt_core;

   localparam logic [7:0]  RST8  = 8'h5A;
   localparam logic [15:0] RST16 = 16'h1234;

   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_DONE = 2;

   logic pclk = 1'b0;
   logic preset_n;
   always #5 pclk = ~pclk;

   // 8-bit instance
   logic       tmr_edge, cnt_enable, cnt_load, cnt_dir;
   logic [7:0] cnt_load_value, reload_value, cmp_value;
   logic [1:0] cnt_mode;
   logic [2:0] flag_clr;
   logic [7:0] tcnt;
   logic       ovf_pulse, udf_pulse, cmp_pulse, ovf_flag, udf_flag, cmp_flag, running;

   // 16-bit instance
   logic        s16_edge, s16_enable, s16_load, s16_dir;
   logic [15:0] s16_load_value, s16_reload_value, s16_cmp_value;
   logic [1:0]  s16_mode;
   logic [2:0]  s16_flag_clr;
   logic [15:0] s16_tcnt;
   logic        s16_ovf_pulse, s16_udf_pulse, s16_cmp_pulse;
   logic        s16_ovf_flag, s16_udf_flag, s16_cmp_flag, s16_running;

   tmr_cnt_core #(.CNT_WIDTH(8), .TCNT_RST(RST8)) u_dut8 (
      .pclk           (pclk),
      .preset_n       (preset_n),
      .tmr_edge       (tmr_edge),
      .cnt_enable     (cnt_enable),
      .cnt_load       (cnt_load),
      .cnt_load_value (cnt_load_value),
      .cnt_dir        (cnt_dir),
      .cnt_mode       (cnt_mode),
      .reload_value   (reload_value),
      .cmp_value      (cmp_value),
      .flag_clr       (flag_clr),
      .tcnt           (tcnt),
      .ovf_pulse      (ovf_pulse),
      .udf_pulse      (udf_pulse),
      .cmp_pulse      (cmp_pulse),
      .ovf_flag       (ovf_flag),
      .udf_flag       (udf_flag),
      .cmp_flag       (cmp_flag),
      .running        (running)
   );

   tmr_cnt_core #(.CNT_WIDTH(16), .TCNT_RST(RST16)) u_dut16 (
      .pclk           (pclk),
      .preset_n       (preset_n),
      .tmr_edge       (s16_edge),
      .cnt_enable     (s16_enable),
      .cnt_load       (s16_load),
      .cnt_load_value (s16_load_value),
      .cnt_dir        (s16_dir),
      .cnt_mode       (s16_mode),
      .reload_value   (s16_reload_value),
      .cmp_value      (s16_cmp_value),
      .flag_clr       (s16_flag_clr),
      .tcnt           (s16_tcnt),
      .ovf_pulse      (s16_ovf_pulse),
      .udf_pulse      (s16_udf_pulse),
      .cmp_pulse      (s16_cmp_pulse),
      .ovf_flag       (s16_ovf_flag),
      .udf_flag       (s16_udf_flag),
      .cmp_flag       (s16_cmp_flag),
      .running        (s16_running)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model of the 8-bit instance
   // ---------------------------------------------------------------------
   int       m_tcnt;
   int       m_phase;
   bit       m_ovf, m_udf, m_cmp;
   bit [2:0] m_flags;

   task automatic model_reset();
      m_tcnt  = int'(RST8);
      m_phase = PH_IDLE;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_cmp   = 1'b0;
      m_flags = 3'b000;
   endtask

   task automatic model_step();
      bit stp, term;
      int nxt;
      stp  = cnt_enable && tmr_edge && (m_phase == PH_RUN) && !cnt_load;
      term = cnt_dir ? (m_tcnt == 0) : (m_tcnt == 255);
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_cmp = 1'b0;
      if (cnt_load) begin
         m_tcnt = int'(cnt_load_value);
      end else if (stp) begin
         if (!term) begin
            nxt = cnt_dir ? (m_tcnt + 255) % 256 : (m_tcnt + 1) % 256;
         end else begin
            if (cnt_dir) m_udf = 1'b1;
            else         m_ovf = 1'b1;
            if (cnt_mode == 2'd1)      nxt = int'(reload_value);
            else if (cnt_mode == 2'd2) nxt = m_tcnt;
            else                       nxt = cnt_dir ? 255 : 0;
         end
         m_cmp  = (nxt == int'(cmp_value));
         m_tcnt = nxt;
      end
      if (m_phase == PH_IDLE) begin
         if (cnt_enable) m_phase = PH_RUN;
      end else if (m_phase == PH_RUN) begin
         if (!cnt_enable)                           m_phase = PH_IDLE;
         else if (stp && term && cnt_mode == 2'd2)  m_phase = PH_DONE;
      end else begin
         if (cnt_load || !cnt_enable) m_phase = PH_IDLE;
      end
      m_flags = {m_cmp, m_udf, m_ovf} | (m_flags & ~flag_clr);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " tcnt"},      int'(tcnt),      m_tcnt);
      chk({tag, " ovf_pulse"}, int'(ovf_pulse), int'(m_ovf));
      chk({tag, " udf_pulse"}, int'(udf_pulse), int'(m_udf));
      chk({tag, " cmp_pulse"}, int'(cmp_pulse), int'(m_cmp));
      chk({tag, " ovf_flag"},  int'(ovf_flag),  int'(m_flags[0]));
      chk({tag, " udf_flag"},  int'(udf_flag),  int'(m_flags[1]));
      chk({tag, " cmp_flag"},  int'(cmp_flag),  int'(m_flags[2]));
      chk({tag, " running"},   int'(running),   int'(m_phase == PH_RUN));
   endtask

   // Advance one clock: model consumes the inputs that the edge samples.
   task automatic tick(input bit do_check, input string tag);
      model_step();
      @(posedge pclk);
      #1;
      if (do_check) check_model(tag);
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table (8-bit instance)
   // ---------------------------------------------------------------------
   typedef struct {
      int en, edg, ld, lval, dir, mode, rld, cmp, clr;
      int e_tcnt, e_pulse, e_flags, e_run;   // pulse/flags as {cmp,udf,ovf}
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int en, input int edg, input int ld, input int lval,
                          input int dir, input int mode, input int rld, input int cmp,
                          input int clr, input int e_tcnt, input int e_pulse,
                          input int e_flags, input int e_run);
      vec_t v;
      v.en = en; v.edg = edg; v.ld = ld; v.lval = lval; v.dir = dir; v.mode = mode;
      v.rld = rld; v.cmp = cmp; v.clr = clr; v.e_tcnt = e_tcnt; v.e_pulse = e_pulse;
      v.e_flags = e_flags; v.e_run = e_run;
      vecs.push_back(v);
   endtask

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 6))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'hFE;
         3:       return 8'h01;
         4:       return 8'h03;
         5:       return 8'h80;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      preset_n       = 1'b0;
      tmr_edge       = 1'b0;
      cnt_enable     = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = 8'h00;
      cnt_dir        = 1'b0;
      cnt_mode       = 2'b00;
      reload_value   = 8'h00;
      cmp_value      = 8'h80;
      flag_clr       = 3'b000;
      s16_edge         = 1'b0;
      s16_enable       = 1'b0;
      s16_load         = 1'b0;
      s16_load_value   = 16'h0000;
      s16_dir          = 1'b0;
      s16_mode         = 2'b00;
      s16_reload_value = 16'h0000;
      s16_cmp_value    = 16'h8000;
      s16_flag_clr     = 3'b000;
      model_reset();

      // ---------------- reset values ----------------
      repeat (2) @(posedge pclk);
      #1;
      check_model("reset8");
      chk("reset16 tcnt",    int'(s16_tcnt),    int'(RST16));
      chk("reset16 running", int'(s16_running), 0);
      @(negedge pclk);
      preset_n = 1'b1;

      // en edg ld lval dir mode rld cmp clr | tcnt pulse flags run
      // free-run up through overflow
      add_vec(1,0,1,'hFE,0,0,'h00,'h80,0,   'hFE,0,0,1);
      add_vec(1,1,0,'hFE,0,0,'h00,'h80,0,   'hFF,0,0,1);
      add_vec(1,1,0,'hFE,0,0,'h00,'h80,0,   'h00,1,1,1);
      add_vec(1,0,0,'hFE,0,0,'h00,'h80,6,   'h00,0,1,1);
      add_vec(1,0,0,'hFE,0,0,'h00,'h80,1,   'h00,0,0,1);
      // auto-reload down through underflow
      add_vec(1,0,1,'h01,1,1,'h05,'h80,0,   'h01,0,0,1);
      add_vec(1,1,0,'h01,1,1,'h05,'h80,0,   'h00,0,0,1);
      add_vec(1,1,0,'h01,1,1,'h05,'h80,0,   'h05,2,2,1);
      add_vec(1,1,0,'h01,1,1,'h05,'h80,0,   'h04,0,2,1);
      add_vec(1,0,0,'h01,1,1,'h05,'h80,2,   'h04,0,0,1);
      // one-shot up, expiry, re-arm by load
      add_vec(1,0,1,'hFD,0,2,'h00,'h80,0,   'hFD,0,0,1);
      add_vec(1,1,0,'hFD,0,2,'h00,'h80,0,   'hFE,0,0,1);
      add_vec(1,1,0,'hFD,0,2,'h00,'h80,0,   'hFF,0,0,1);
      add_vec(1,1,0,'hFD,0,2,'h00,'h80,0,   'hFF,1,1,0);
      add_vec(1,1,0,'hFD,0,2,'h00,'h80,0,   'hFF,0,1,0);
      add_vec(1,1,1,'h10,0,2,'h00,'h80,1,   'h10,0,0,0);
      add_vec(1,0,0,'h10,0,2,'h00,'h80,0,   'h10,0,0,1);
      add_vec(1,1,0,'h10,0,2,'h00,'h80,0,   'h11,0,0,1);
      // compare match, load never matches, set beats clear
      add_vec(1,0,1,'h00,0,0,'h00,'h03,0,   'h00,0,0,1);
      add_vec(1,1,0,'h00,0,0,'h00,'h03,0,   'h01,0,0,1);
      add_vec(1,1,0,'h00,0,0,'h00,'h03,0,   'h02,0,0,1);
      add_vec(1,1,0,'h00,0,0,'h00,'h03,0,   'h03,4,4,1);
      add_vec(1,1,1,'h03,0,0,'h00,'h03,0,   'h03,0,4,1);
      add_vec(1,0,1,'h02,0,0,'h00,'h03,0,   'h02,0,4,1);
      add_vec(1,1,0,'h02,0,0,'h00,'h03,4,   'h03,4,4,1);
      add_vec(1,0,0,'h02,0,0,'h00,'h03,4,   'h03,0,0,1);
      // load and edge together at all-ones
      add_vec(1,0,1,'hFF,0,0,'h00,'h03,0,   'hFF,0,0,1);
      add_vec(1,1,1,'h42,0,0,'h00,'h03,0,   'h42,0,0,1);
      // overflow and compare in the same cycle
      add_vec(1,0,1,'hFF,0,0,'h00,'h00,0,   'hFF,0,0,1);
      add_vec(1,1,0,'hFF,0,0,'h00,'h00,0,   'h00,5,5,1);
      add_vec(1,0,0,'hFF,0,0,'h00,'h00,5,   'h00,0,0,1);
      // mode 11 behaves as free-run
      add_vec(1,0,1,'hFF,0,3,'h77,'h80,0,   'hFF,0,0,1);
      add_vec(1,1,0,'hFF,0,3,'h77,'h80,0,   'h00,1,1,1);
      add_vec(1,0,0,'hFF,0,3,'h77,'h80,1,   'h00,0,0,1);
      // disable: no step, back to IDLE
      add_vec(0,1,0,'hFF,0,0,'h00,'h80,0,   'h00,0,0,0);
      add_vec(0,1,0,'hFF,0,0,'h00,'h80,0,   'h00,0,0,0);

      foreach (vecs[i]) begin
         cnt_enable     = 1'(vecs[i].en);
         tmr_edge       = 1'(vecs[i].edg);
         cnt_load       = 1'(vecs[i].ld);
         cnt_load_value = 8'(vecs[i].lval);
         cnt_dir        = 1'(vecs[i].dir);
         cnt_mode       = 2'(vecs[i].mode);
         reload_value   = 8'(vecs[i].rld);
         cmp_value      = 8'(vecs[i].cmp);
         flag_clr       = 3'(vecs[i].clr);
         tick(1'b0, "vec");
         chk($sformatf("vec%0d tcnt", i),    int'(tcnt), vecs[i].e_tcnt);
         chk($sformatf("vec%0d pulses", i),  int'({cmp_pulse, udf_pulse, ovf_pulse}), vecs[i].e_pulse);
         chk($sformatf("vec%0d flags", i),   int'({cmp_flag, udf_flag, ovf_flag}), vecs[i].e_flags);
         chk($sformatf("vec%0d running", i), int'(running), vecs[i].e_run);
      end
      flag_clr = 3'b000;

      // ---------------- random stimulus vs model ----------------
      for (int i = 0; i < 3000; i++) begin
         cnt_enable     = ($urandom_range(0, 19) != 0);
         tmr_edge       = 1'($urandom_range(0, 1));
         cnt_load       = ($urandom_range(0, 15) == 0);
         cnt_load_value = pick8();
         if ($urandom_range(0, 31) == 0) cnt_dir      = ~cnt_dir;
         if ($urandom_range(0, 31) == 0) cnt_mode     = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) reload_value = pick8();
         if ($urandom_range(0, 15) == 0) cmp_value    = pick8();
         flag_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         tick(1'b1, "rand");
         if (i == 1500) begin
            #2 preset_n = 1'b0;
            #1;
            model_reset();
            check_model("rand_reset");
            @(negedge pclk);
            preset_n = 1'b1;
         end
      end

      // ---------------- 16-bit: down wrap, then reset mid-count ----------------
      cnt_enable = 1'b0;
      cnt_load   = 1'b0;
      tmr_edge   = 1'b0;
      flag_clr   = 3'b000;
      s16_enable     = 1'b1;
      s16_load       = 1'b1;
      s16_load_value = 16'h0000;
      s16_dir        = 1'b1;
      s16_mode       = 2'b00;
      s16_cmp_value  = 16'hFFFE;
      tick(1'b1, "s16a");
      chk("w16 load tcnt", int'(s16_tcnt), 'h0000);
      chk("w16 running",   int'(s16_running), 1);
      s16_load = 1'b0;
      s16_edge = 1'b1;
      tick(1'b1, "s16b");
      chk("w16 wrap tcnt",  int'(s16_tcnt), 'hFFFF);
      chk("w16 udf_pulse",  int'(s16_udf_pulse), 1);
      chk("w16 ovf_pulse",  int'(s16_ovf_pulse), 0);
      chk("w16 udf_flag",   int'(s16_udf_flag), 1);
      tick(1'b1, "s16c");
      chk("w16 tcnt FFFE",  int'(s16_tcnt), 'hFFFE);
      chk("w16 cmp_pulse",  int'(s16_cmp_pulse), 1);
      chk("w16 udf_pulse2", int'(s16_udf_pulse), 0);
      chk("w16 flags",      int'({s16_cmp_flag, s16_udf_flag, s16_ovf_flag}), 6);
      tick(1'b1, "s16d");
      chk("w16 tcnt FFFD",  int'(s16_tcnt), 'hFFFD);
      #2 preset_n = 1'b0;
      #1;
      chk("w16 rst tcnt",    int'(s16_tcnt), int'(RST16));
      chk("w16 rst flags",   int'({s16_cmp_flag, s16_udf_flag, s16_ovf_flag}), 0);
      chk("w16 rst pulses",  int'({s16_cmp_pulse, s16_udf_pulse, s16_ovf_pulse}), 0);
      chk("w16 rst running", int'(s16_running), 0);
      model_reset();
      check_model("s16_rst8");
      s16_enable = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      tick(1'b1, "s16e");
      chk("w16 post-rst tcnt", int'(s16_tcnt), int'(RST16));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
